game_fsm_controller: RTL and testbench

Top-level game sequencer for the Sudoku design. It turns raw button levels into single-cycle events and steps the game through its screens: start, difficulty select, puzzle load, play, win and lose. While playing it owns the cursor and issues cell writes to the board datapath. It tracks mistakes and score, and gates the game timer.

---
 rtl/sudoku_pkg.sv | 61 ++++++
 rtl/game_fsm_controller_button_edge.sv | 33 +++
 rtl/game_fsm_controller.sv | 224 ++++++++++++++++++++++
 tb/tb_game_fsm_controller.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_pkg.sv
// Shared encodings for the Sudoku game sequencer: states, events, grid limits, button map.
package sudoku_pkg;

  localparam int unsigned NUM_BTN   = 7;

  // Button bit positions, listed from highest to lowest event priority
  localparam int unsigned BTN_A     = 0;
  localparam int unsigned BTN_B     = 1;
  localparam int unsigned BTN_UP    = 2;
  localparam int unsigned BTN_DOWN  = 3;
  localparam int unsigned BTN_LEFT  = 4;
  localparam int unsigned BTN_RIGHT = 5;
  localparam int unsigned BTN_START = 6;

  localparam logic [3:0] GRID_MAX  = 4'd8;
  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] EMPTY     = 4'd0;

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_DIFF  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_CHECK = 3'd4,
    ST_WIN   = 3'd5,
    ST_LOSE  = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    EV_NONE  = 3'd0,
    EV_A     = 3'd1,
    EV_B     = 3'd2,
    EV_UP    = 3'd3,
    EV_DOWN  = 3'd4,
    EV_LEFT  = 3'd5,
    EV_RIGHT = 3'd6,
    EV_START = 3'd7
  } event_e;

  // Keep only the highest-priority event of the cycle
  function automatic event_e pick_event(input logic [NUM_BTN-1:0] ev);
    if (ev[BTN_A])          return EV_A;
    else if (ev[BTN_B])     return EV_B;
    else if (ev[BTN_UP])    return EV_UP;
    else if (ev[BTN_DOWN])  return EV_DOWN;
    else if (ev[BTN_LEFT])  return EV_LEFT;
    else if (ev[BTN_RIGHT]) return EV_RIGHT;
    else if (ev[BTN_START]) return EV_START;
    else                    return EV_NONE;
  endfunction

  // Cursor step with wrap-around over 0..GRID_MAX
  function automatic logic [3:0] grid_inc(input logic [3:0] p);
    return (p >= GRID_MAX) ? 4'd0 : p + 4'd1;
  endfunction

  function automatic logic [3:0] grid_dec(input logic [3:0] p);
    return (p == 4'd0) ? GRID_MAX : p - 4'd1;
  endfunction

endpackage

// File: rtl/game_fsm_controller_button_edge.sv
// Registered rising-edge detector: one event per press, regardless of hold time.
module button_edge
  import sudoku_pkg::*;
(
  input  logic               clk_50MHz,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn,
  output logic [NUM_BTN-1:0] evt
);

  logic [NUM_BTN-1:0] prev_q, prev_d;
  logic [NUM_BTN-1:0] evt_q, evt_d;

  // Event is a level that was low on the previous cycle
  always_comb begin
    prev_d = btn;
    evt_d  = btn & ~prev_q;
  end

  // Previous-level and event registers
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      prev_q <= '0;
      evt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      evt_q  <= evt_d;
    end
  end

  assign evt = evt_q;

endmodule

// File: rtl/game_fsm_controller.sv
// Sudoku game sequencer: screen flow, cursor, cell writes, mistakes, score and timer gating.
module game_fsm_controller
  import sudoku_pkg::*;
#(
  parameter int unsigned NUM_DIFF   = 3,
  parameter int unsigned MAX_ERRORS = 3,
  parameter int unsigned SCORE_W    = 7
) (
  input  logic               clk_50MHz,
  input  logic               reset,
  input  logic               a_button,
  input  logic               b_button,
  input  logic               up_button,
  input  logic               down_button,
  input  logic               left_button,
  input  logic               right_button,
  input  logic               start_button,
  input  logic               load_done,
  input  logic               cell_fixed,
  input  logic [3:0]         cell_value,
  input  logic               cell_conflict,
  input  logic               board_solved,
  input  logic               timeout,
  output logic [2:0]         state,
  output logic [1:0]         difficulty,
  output logic [3:0]         pos_x,
  output logic [3:0]         pos_y,
  output logic               load_start,
  output logic               cell_we,
  output logic [3:0]         cell_wdata,
  output logic               error,
  output logic [SCORE_W-1:0] score,
  output logic               timer_en,
  output logic               timer_clear
);

  localparam int unsigned      ERR_W     = $clog2(MAX_ERRORS + 1);
  localparam logic [ERR_W-1:0] ERR_LIMIT = ERR_W'(MAX_ERRORS);
  localparam logic [1:0]       DIFF_MAX  = 2'(NUM_DIFF - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  logic [NUM_BTN-1:0] btn, evt;
  event_e             ev;

  state_e             state_q, state_d;
  logic [1:0]         diff_q, diff_d;
  logic [3:0]         pos_x_q, pos_x_d;
  logic [3:0]         pos_y_q, pos_y_d;
  logic               load_start_q, load_start_d;
  logic               cell_we_q, cell_we_d;
  logic [3:0]         cell_wdata_q, cell_wdata_d;
  logic               error_q, error_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               timer_en_q, timer_en_d;
  logic               timer_clear_q, timer_clear_d;

  assign btn[BTN_A]     = a_button;
  assign btn[BTN_B]     = b_button;
  assign btn[BTN_UP]    = up_button;
  assign btn[BTN_DOWN]  = down_button;
  assign btn[BTN_LEFT]  = left_button;
  assign btn[BTN_RIGHT] = right_button;
  assign btn[BTN_START] = start_button;

  button_edge u_button_edge (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .btn       (btn),
    .evt       (evt)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    diff_d        = diff_q;
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    load_start_d  = 1'b0;
    cell_we_d     = 1'b0;
    cell_wdata_d  = cell_wdata_q;
    error_d       = error_q;
    score_d       = score_q;
    err_cnt_d     = err_cnt_q;
    timer_clear_d = 1'b0;
    ev            = pick_event(evt);

    case (state_q)
      ST_START: begin
        if (ev == EV_START) begin
          state_d = ST_DIFF;
          diff_d  = 2'd0;
        end
      end

      ST_DIFF: begin
        case (ev)
          EV_DOWN: if (diff_q < DIFF_MAX) diff_d = diff_q + 2'd1;
          EV_UP:   if (diff_q != 2'd0)    diff_d = diff_q - 2'd1;
          EV_B:    state_d = ST_START;
          EV_A: begin
            // Game setup happens on entry so LOAD already shows a clean board state
            state_d       = ST_LOAD;
            load_start_d  = 1'b1;
            timer_clear_d = 1'b1;
            pos_x_d       = 4'd0;
            pos_y_d       = 4'd0;
            score_d       = '0;
            err_cnt_d     = '0;
            error_d       = 1'b0;
          end
          default: ;
        endcase
      end

      ST_LOAD: begin
        if (load_done) state_d = ST_PLAY;
      end

      ST_PLAY: begin
        if (timeout) begin
          state_d = ST_LOSE;
        end else if (board_solved) begin
          state_d = ST_WIN;
        end else begin
          case (ev)
            EV_RIGHT: pos_x_d = grid_inc(pos_x_q);
            EV_LEFT:  pos_x_d = grid_dec(pos_x_q);
            EV_DOWN:  pos_y_d = grid_inc(pos_y_q);
            EV_UP:    pos_y_d = grid_dec(pos_y_q);
            EV_A: begin
              if (!cell_fixed) begin
                cell_we_d    = 1'b1;
                cell_wdata_d = (cell_value >= DIGIT_MAX) ? 4'd1 : cell_value + 4'd1;
                state_d      = ST_CHECK;
              end
            end
            EV_B: begin
              if (!cell_fixed && (cell_value != EMPTY)) begin
                cell_we_d    = 1'b1;
                cell_wdata_d = EMPTY;
                state_d      = ST_CHECK;
              end
            end
            default: ;
          endcase
        end
      end

      ST_CHECK: begin
        // Single-cycle verdict on the write; events this cycle are ignored
        if (cell_conflict) begin
          error_d   = 1'b1;
          err_cnt_d = err_cnt_q + ERR_W'(1);
          state_d   = (err_cnt_d >= ERR_LIMIT) ? ST_LOSE : ST_PLAY;
        end else begin
          error_d = 1'b0;
          if ((cell_wdata_q != EMPTY) && (score_q != SCORE_MAX))
            score_d = score_q + SCORE_W'(1);
          state_d = ST_PLAY;
        end
      end

      ST_WIN, ST_LOSE: begin
        if (ev == EV_START) begin
          state_d   = ST_START;
          pos_x_d   = 4'd0;
          pos_y_d   = 4'd0;
          score_d   = '0;
          err_cnt_d = '0;
          error_d   = 1'b0;
        end
      end

      default: state_d = ST_START;
    endcase

    timer_en_d = (state_d == ST_PLAY) || (state_d == ST_CHECK);
  end

  // State and output registers
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q       <= ST_START;
      diff_q        <= 2'd0;
      pos_x_q       <= 4'd0;
      pos_y_q       <= 4'd0;
      load_start_q  <= 1'b0;
      cell_we_q     <= 1'b0;
      cell_wdata_q  <= 4'd0;
      error_q       <= 1'b0;
      score_q       <= '0;
      err_cnt_q     <= '0;
      timer_en_q    <= 1'b0;
      timer_clear_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      diff_q        <= diff_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      load_start_q  <= load_start_d;
      cell_we_q     <= cell_we_d;
      cell_wdata_q  <= cell_wdata_d;
      error_q       <= error_d;
      score_q       <= score_d;
      err_cnt_q     <= err_cnt_d;
      timer_en_q    <= timer_en_d;
      timer_clear_q <= timer_clear_d;
    end
  end

  assign state       = state_q;
  assign difficulty  = diff_q;
  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign load_start  = load_start_q;
  assign cell_we     = cell_we_q;
  assign cell_wdata  = cell_wdata_q;
  assign error       = error_q;
  assign score       = score_q;
  assign timer_en    = timer_en_q;
  assign timer_clear = timer_clear_q;

endmodule

// File: tb/tb_game_fsm_controller.sv
// Directed bench for the Sudoku game sequencer.
module tb_game_fsm_controller;

  localparam int B_A = 0, B_B = 1, B_UP = 2, B_DOWN = 3, B_LEFT = 4, B_RIGHT = 5, B_START = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] btn = '0;
  logic       load_done = 1'b0;
  logic       cell_fixed = 1'b0;
  logic [3:0] cell_value = 4'd0;
  logic       cell_conflict = 1'b0;
  logic       board_solved = 1'b0;
  logic       timeout = 1'b0;

  logic [2:0] state;
  logic [1:0] difficulty;
  logic [3:0] pos_x, pos_y;
  logic       load_start, cell_we, error, timer_en, timer_clear;
  logic [3:0] cell_wdata;
  logic [6:0] score;

  int total = 0;
  int bad = 0;
  int load_cnt = 0;
  int clr_cnt = 0;

  game_fsm_controller dut (
    .clk_50MHz     (clk),
    .reset         (reset),
    .a_button      (btn[0]),
    .b_button      (btn[1]),
    .up_button     (btn[2]),
    .down_button   (btn[3]),
    .left_button   (btn[4]),
    .right_button  (btn[5]),
    .start_button  (btn[6]),
    .load_done     (load_done),
    .cell_fixed    (cell_fixed),
    .cell_value    (cell_value),
    .cell_conflict (cell_conflict),
    .board_solved  (board_solved),
    .timeout       (timeout),
    .state         (state),
    .difficulty    (difficulty),
    .pos_x         (pos_x),
    .pos_y         (pos_y),
    .load_start    (load_start),
    .cell_we       (cell_we),
    .cell_wdata    (cell_wdata),
    .error         (error),
    .score         (score),
    .timer_en      (timer_en),
    .timer_clear   (timer_clear)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load_start)  load_cnt++;
    if (timer_clear) clr_cnt++;
  end

  // Hold buttons for one cycle; returns once the FSM has reacted to the event
  task automatic press(input logic [6:0] mask);
    btn = mask;
    @(negedge clk);
    btn = '0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++; if ({difficulty, pos_x, pos_y, score} !== 17'd0) begin bad++; $display("FAIL reset_regs got=%0h want=0", {difficulty, pos_x, pos_y, score}); end
    total++; if ({load_start, cell_we, cell_wdata, error, timer_en, timer_clear} !== 9'd0) begin bad++; $display("FAIL reset_outs got=%0h want=0", {load_start, cell_we, cell_wdata, error, timer_en, timer_clear}); end
    reset = 1'b0;
  endtask

  task automatic test_start_flow;
    load_cnt = 0;
    clr_cnt  = 0;
    btn[B_START] = 1'b1;
    repeat (3) @(negedge clk);
    btn = '0;
    @(negedge clk);
    total++; if (state !== 3'd1) begin bad++; $display("FAIL flow_diff got=%0d want=1", state); end
    total++; if (difficulty !== 2'd0) begin bad++; $display("FAIL flow_diff0 got=%0d want=0", difficulty); end
    press(7'b1 << B_DOWN);
    total++; if (difficulty !== 2'd1) begin bad++; $display("FAIL flow_down got=%0d want=1", difficulty); end
    press(7'b1 << B_A);
    total++; if (state !== 3'd2 || load_start !== 1'b1 || timer_clear !== 1'b1) begin bad++; $display("FAIL flow_load got=%0d/%0b/%0b want=2/1/1", state, load_start, timer_clear); end
    @(negedge clk);
    total++; if (state !== 3'd2 || load_start !== 1'b0 || timer_clear !== 1'b0) begin bad++; $display("FAIL flow_load2 got=%0d/%0b/%0b want=2/0/0", state, load_start, timer_clear); end
    load_done = 1'b1;
    @(negedge clk);
    load_done = 1'b0;
    total++; if (state !== 3'd3 || timer_en !== 1'b1) begin bad++; $display("FAIL flow_play got=%0d/%0b want=3/1", state, timer_en); end
    total++; if (load_cnt !== 1 || clr_cnt !== 1) begin bad++; $display("FAIL flow_pulses got=%0d/%0d want=1/1", load_cnt, clr_cnt); end
    total++; if (difficulty !== 2'd1 || pos_x !== 4'd0 || pos_y !== 4'd0) begin bad++; $display("FAIL flow_regs got=%0d/%0d/%0d want=1/0/0", difficulty, pos_x, pos_y); end
  endtask

  task automatic test_cursor;
    press(7'b1 << B_LEFT);
    total++; if (pos_x !== 4'd8) begin bad++; $display("FAIL cur_left got=%0d want=8", pos_x); end
    press(7'b1 << B_UP);
    total++; if (pos_y !== 4'd8) begin bad++; $display("FAIL cur_up got=%0d want=8", pos_y); end
    press(7'b1 << B_RIGHT);
    total++; if (pos_x !== 4'd0) begin bad++; $display("FAIL cur_right got=%0d want=0", pos_x); end
    btn[B_RIGHT] = 1'b1;
    repeat (4) @(negedge clk);
    btn = '0;
    @(negedge clk);
    total++; if (pos_x !== 4'd1) begin bad++; $display("FAIL cur_hold got=%0d want=1", pos_x); end
    press(7'b1 << B_DOWN);
    total++; if (pos_y !== 4'd0) begin bad++; $display("FAIL cur_down got=%0d want=0", pos_y); end
  endtask

  task automatic test_write;
    cell_fixed = 1'b0; cell_value = 4'd0; cell_conflict = 1'b0;
    press(7'b1 << B_A);
    total++; if (state !== 3'd4 || cell_we !== 1'b1 || cell_wdata !== 4'd1) begin bad++; $display("FAIL wr_a got=%0d/%0b/%0d want=4/1/1", state, cell_we, cell_wdata); end
    total++; if (timer_en !== 1'b1) begin bad++; $display("FAIL wr_timer got=%0b want=1", timer_en); end
    @(negedge clk);
    total++; if (state !== 3'd3 || cell_we !== 1'b0 || score !== 7'd1) begin bad++; $display("FAIL wr_done got=%0d/%0b/%0d want=3/0/1", state, cell_we, score); end
    cell_value = 4'd9;
    press(7'b1 << B_A);
    total++; if (cell_we !== 1'b1 || cell_wdata !== 4'd1) begin bad++; $display("FAIL wr_wrap got=%0b/%0d want=1/1", cell_we, cell_wdata); end
    @(negedge clk);
    total++; if (score !== 7'd2) begin bad++; $display("FAIL wr_score2 got=%0d want=2", score); end
    cell_value = 4'd5;
    press(7'b1 << B_B);
    total++; if (state !== 3'd4 || cell_wdata !== 4'd0) begin bad++; $display("FAIL wr_clear got=%0d/%0d want=4/0", state, cell_wdata); end
    @(negedge clk);
    total++; if (score !== 7'd2 || error !== 1'b0) begin bad++; $display("FAIL wr_clear_score got=%0d/%0b want=2/0", score, error); end
    cell_value = 4'd0;
    press(7'b1 << B_B);
    total++; if (state !== 3'd3 || cell_we !== 1'b0) begin bad++; $display("FAIL wr_b_empty got=%0d/%0b want=3/0", state, cell_we); end
  endtask

  task automatic test_fixed_simultaneous;
    cell_fixed = 1'b1; cell_value = 4'd4;
    press((7'b1 << B_A) | (7'b1 << B_RIGHT));
    total++; if (state !== 3'd3 || cell_we !== 1'b0 || pos_x !== 4'd1) begin bad++; $display("FAIL fixed_ar got=%0d/%0b/%0d want=3/0/1", state, cell_we, pos_x); end
    cell_fixed = 1'b0;
  endtask

  task automatic test_conflicts;
    cell_value = 4'd3; cell_conflict = 1'b1;
    for (int i = 0; i < 3; i++) begin
      press(7'b1 << B_A);
      total++; if (state !== 3'd4 || cell_wdata !== 4'd4) begin bad++; $display("FAIL conf_chk%0d got=%0d/%0d want=4/4", i, state, cell_wdata); end
      @(negedge clk);
      total++; if (error !== 1'b1) begin bad++; $display("FAIL conf_err%0d got=%0b want=1", i, error); end
      total++; if (state !== ((i < 2) ? 3'd3 : 3'd6) || timer_en !== (i < 2)) begin bad++; $display("FAIL conf_st%0d got=%0d/%0b want=%0d/%0b", i, state, timer_en, (i < 2) ? 3 : 6, i < 2); end
    end
    cell_conflict = 1'b0;
    total++; if (score !== 7'd2) begin bad++; $display("FAIL conf_score got=%0d want=2", score); end
    press(7'b1 << B_START);
    total++; if (state !== 3'd0) begin bad++; $display("FAIL conf_restart got=%0d want=0", state); end
  endtask

  task automatic test_diff_sat;
    press(7'b1 << B_START);
    total++; if (state !== 3'd1 || difficulty !== 2'd0) begin bad++; $display("FAIL sat_enter got=%0d/%0d want=1/0", state, difficulty); end
    press(7'b1 << B_DOWN);
    press(7'b1 << B_UP);
    press(7'b1 << B_UP);
    total++; if (difficulty !== 2'd0) begin bad++; $display("FAIL sat_low got=%0d want=0", difficulty); end
    for (int i = 0; i < 4; i++) press(7'b1 << B_DOWN);
    total++; if (difficulty !== 2'd2) begin bad++; $display("FAIL sat_high got=%0d want=2", difficulty); end
    press(7'b1 << B_A);
    load_done = 1'b1;
    @(negedge clk);
    load_done = 1'b0;
    total++; if (state !== 3'd3 || pos_x !== 4'd0 || score !== 7'd0 || error !== 1'b0) begin bad++; $display("FAIL sat_play got=%0d/%0d/%0d/%0b want=3/0/0/0", state, pos_x, score, error); end
  endtask

  task automatic test_solved_timeout;
    board_solved = 1'b1; timeout = 1'b1;
    @(negedge clk);
    board_solved = 1'b0; timeout = 1'b0;
    total++; if (state !== 3'd6 || timer_en !== 1'b0) begin bad++; $display("FAIL both_lose got=%0d/%0b want=6/0", state, timer_en); end
    press(7'b1 << B_START);
    press(7'b1 << B_START);
    press(7'b1 << B_A);
    load_done = 1'b1;
    @(negedge clk);
    load_done = 1'b0;
    board_solved = 1'b1;
    @(negedge clk);
    board_solved = 1'b0;
    total++; if (state !== 3'd5 || timer_en !== 1'b0) begin bad++; $display("FAIL solved_win got=%0d/%0b want=5/0", state, timer_en); end
    press(7'b1 << B_START);
  endtask

  task automatic test_reset_in_check;
    press(7'b1 << B_START);
    press(7'b1 << B_A);
    load_done = 1'b1;
    @(negedge clk);
    load_done = 1'b0;
    cell_fixed = 1'b0; cell_value = 4'd6; cell_conflict = 1'b0;
    press(7'b1 << B_A);
    total++; if (state !== 3'd4) begin bad++; $display("FAIL rst_chk_pre got=%0d want=4", state); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (state !== 3'd0 || {difficulty, pos_x, pos_y, score} !== 17'd0) begin bad++; $display("FAIL rst_chk_regs got=%0d/%0h want=0/0", state, {difficulty, pos_x, pos_y, score}); end
    total++; if ({load_start, cell_we, cell_wdata, error, timer_en, timer_clear} !== 9'd0) begin bad++; $display("FAIL rst_chk_outs got=%0h want=0", {load_start, cell_we, cell_wdata, error, timer_en, timer_clear}); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_start_flow;
    test_cursor;
    test_write;
    test_fixed_simultaneous;
    test_conflicts;
    test_diff_sat;
    test_solved_timeout;
    test_reset_in_check;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
